// File: rtl/hashchecker_pkg.sv
// Shared types and helpers for the multi-lane hash store/check block.
package hashchecker_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Index width that never collapses to zero bits for tiny depths/lane counts.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hash_lane_cmp.sv
// LANES-wide masked equality compare; reports whether any valid lane hits
// and the lowest hitting lane offset.
module hash_lane_cmp
    import hashchecker_pkg::*;
#(
    parameter int HASH_WIDTH = 128,
    parameter int LANES      = 1,
    parameter int OFF_W      = 1
) (
    input  logic [HASH_WIDTH-1:0] key_i,
    input  logic [HASH_WIDTH-1:0] slot_i [LANES],
    input  logic [LANES-1:0]      valid_i,
    output logic                  hit_o,
    output logic [OFF_W-1:0]      off_o
);

    // Walk from the top lane down so the lowest hit is the one left standing.
    always_comb begin
        hit_o = 1'b0;
        off_o = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (valid_i[i] && (slot_i[i] == key_i)) begin
                hit_o = 1'b1;
                off_o = OFF_W'(i);
            end
        end
    end

endmodule

// File: rtl/hashchecker_multi.sv
// Stores up to DEPTH target hashes and answers membership queries by scanning
// LANES slots per cycle, reporting the lowest matching slot.
//
// state | meaning
// IDLE  | waiting for a check request; stores still accepted
// SCAN  | comparing key against slots base..base+LANES-1 below bound
module hashchecker_multi
    import hashchecker_pkg::*;
#(
    parameter int  HASH_WIDTH = 128,
    parameter int  DEPTH      = 16,
    parameter int  LANES      = 1,
    localparam int IDX_WIDTH  = idx_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  newrdy_i,
    input  logic                  checkrdy_i,
    input  logic [HASH_WIDTH-1:0] hash_i,
    output logic                  resultrdy_o,
    output logic                  matchfound_o,
    output logic [IDX_WIDTH-1:0]  matchidx_o,
    output logic [IDX_WIDTH:0]    count_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  busy_o
);

    localparam int CNT_W = IDX_WIDTH + 1;
    localparam int OFF_W = idx_width(LANES);

    logic [HASH_WIDTH-1:0] slot_q [DEPTH];
    logic [HASH_WIDTH-1:0] key_q, key_d;
    logic [CNT_W-1:0]      count_q, count_d, bound_q, bound_d, base_q, base_d;
    logic [IDX_WIDTH-1:0]  matchidx_q, matchidx_d;
    logic                  overflow_q, overflow_d, resultrdy_q, resultrdy_d;
    logic                  matchfound_q, matchfound_d;
    logic                  newrdy_q, checkrdy_q;
    state_e                state_q, state_d;

    logic                  new_edge, chk_edge, full, store_en;
    logic [CNT_W-1:0]      lane_idx  [LANES];
    logic [HASH_WIDTH-1:0] lane_slot [LANES];
    logic [LANES-1:0]      lane_valid;
    logic                  lane_hit;
    logic [OFF_W-1:0]      lane_off;
    logic [IDX_WIDTH-1:0]  hit_idx;

    assign new_edge = newrdy_i & ~newrdy_q;
    assign chk_edge = checkrdy_i & ~checkrdy_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign store_en = ~rst_i & ~clear_i & new_edge & ~full;

    // base is a multiple of LANES below DEPTH, so base+l always lands inside the array.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l]   = base_q + CNT_W'(l);
            lane_slot[l]  = slot_q[lane_idx[l][IDX_WIDTH-1:0]];
            lane_valid[l] = (lane_idx[l] < bound_q);
        end
    end

    hash_lane_cmp #(
        .HASH_WIDTH (HASH_WIDTH),
        .LANES      (LANES),
        .OFF_W      (OFF_W)
    ) u_cmp (
        .key_i   (key_q),
        .slot_i  (lane_slot),
        .valid_i (lane_valid),
        .hit_o   (lane_hit),
        .off_o   (lane_off)
    );

    assign hit_idx = base_q[IDX_WIDTH-1:0] + IDX_WIDTH'(lane_off);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        key_d        = key_q;
        bound_d      = bound_q;
        base_d       = base_q;
        resultrdy_d  = resultrdy_q;
        matchfound_d = matchfound_q;
        matchidx_d   = matchidx_q;
        if (clear_i) begin
            state_d      = ST_IDLE;
            count_d      = '0;
            overflow_d   = 1'b0;
            resultrdy_d  = 1'b0;
            matchfound_d = 1'b0;
            matchidx_d   = '0;
        end else begin
            if (new_edge) begin
                if (full) overflow_d = 1'b1;
                else      count_d    = count_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (chk_edge) begin
                        key_d        = hash_i;
                        bound_d      = count_q;
                        base_d       = '0;
                        resultrdy_d  = 1'b0;
                        matchfound_d = 1'b0;
                        matchidx_d   = '0;
                        state_d      = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (lane_hit) begin
                        matchfound_d = 1'b1;
                        matchidx_d   = hit_idx;
                        resultrdy_d  = 1'b1;
                        state_d      = ST_IDLE;
                    end else if (base_q + CNT_W'(LANES) >= bound_q) begin
                        matchfound_d = 1'b0;
                        resultrdy_d  = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        base_d = base_q + CNT_W'(LANES);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            key_q        <= '0;
            bound_q      <= '0;
            base_q       <= '0;
            resultrdy_q  <= 1'b0;
            matchfound_q <= 1'b0;
            matchidx_q   <= '0;
            newrdy_q     <= 1'b0;
            checkrdy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            key_q        <= key_d;
            bound_q      <= bound_d;
            base_q       <= base_d;
            resultrdy_q  <= resultrdy_d;
            matchfound_q <= matchfound_d;
            matchidx_q   <= matchidx_d;
            newrdy_q     <= newrdy_i;
            checkrdy_q   <= checkrdy_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store_en) slot_q[count_q[IDX_WIDTH-1:0]] <= hash_i;
    end

    assign resultrdy_o  = resultrdy_q;
    assign matchfound_o = matchfound_q;
    assign matchidx_o   = matchidx_q;
    assign count_o      = count_q;
    assign full_o       = full;
    assign overflow_o   = overflow_q;
    assign busy_o       = (state_q == ST_SCAN);

endmodule

// File: tb/tb_hashchecker_multi.sv
// Drives three configurations of hashchecker_multi with shared stimulus and
// compares every output each cycle against a list-based reference model.
module tb_hashchecker_multi;

    logic         clk = 1'b0;
    logic         rst, clear, newrdy, checkrdy;
    logic [127:0] hash;

    always #5 clk = ~clk;

    logic       o_rr [3], o_mf [3], o_full [3], o_ovf [3], o_busy [3];
    logic [4:0] o_cnt [3];
    logic [3:0] o_mi  [3];
    logic [4:0] cnt0, cnt2;
    logic [2:0] cnt1;
    logic [3:0] mi0, mi2;
    logic [1:0] mi1;

    assign o_cnt[0] = cnt0;
    assign o_cnt[1] = {2'b00, cnt1};
    assign o_cnt[2] = cnt2;
    assign o_mi[0]  = mi0;
    assign o_mi[1]  = {2'b00, mi1};
    assign o_mi[2]  = mi2;

    hashchecker_multi #(.HASH_WIDTH(128), .DEPTH(16), .LANES(1)) u_d16l1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .newrdy_i(newrdy),
        .checkrdy_i(checkrdy), .hash_i(hash), .resultrdy_o(o_rr[0]),
        .matchfound_o(o_mf[0]), .matchidx_o(mi0), .count_o(cnt0),
        .full_o(o_full[0]), .overflow_o(o_ovf[0]), .busy_o(o_busy[0]));

    hashchecker_multi #(.HASH_WIDTH(128), .DEPTH(4), .LANES(1)) u_d4l1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .newrdy_i(newrdy),
        .checkrdy_i(checkrdy), .hash_i(hash), .resultrdy_o(o_rr[1]),
        .matchfound_o(o_mf[1]), .matchidx_o(mi1), .count_o(cnt1),
        .full_o(o_full[1]), .overflow_o(o_ovf[1]), .busy_o(o_busy[1]));

    hashchecker_multi #(.HASH_WIDTH(128), .DEPTH(16), .LANES(4)) u_d16l4 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .newrdy_i(newrdy),
        .checkrdy_i(checkrdy), .hash_i(hash), .resultrdy_o(o_rr[2]),
        .matchfound_o(o_mf[2]), .matchidx_o(mi2), .count_o(cnt2),
        .full_o(o_full[2]), .overflow_o(o_ovf[2]), .busy_o(o_busy[2]));

    // Reference model: stored hashes as a list, query answered at accept time
    // and released after the latency implied by the lane count.
    int           depth_c [3] = '{16, 4, 16};
    int           lanes_c [3] = '{1, 1, 4};
    logic [127:0] m_slot [3][16];
    int           m_cnt [3], m_mi [3], m_left [3], p_mi [3];
    bit           m_ovf [3], m_busy [3], m_rr [3], m_mf [3], p_mf [3];
    bit           prev_new, prev_chk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ne, ce, was_busy, found;
        int bound, hit;
        ne = newrdy && !prev_new;
        ce = checkrdy && !prev_chk;
        for (int k = 0; k < 3; k++) begin
            if (rst || clear) begin
                m_cnt[k] = 0; m_busy[k] = 0; m_rr[k] = 0; m_mf[k] = 0; m_mi[k] = 0;
                m_ovf[k] = 0;
            end else begin
                was_busy = m_busy[k];
                if (was_busy) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_busy[k] = 0; m_rr[k] = 1; m_mf[k] = p_mf[k]; m_mi[k] = p_mi[k];
                    end
                end
                if (ce && !was_busy) begin
                    bound = m_cnt[k];
                    found = 0;
                    hit   = 0;
                    for (int i = 0; i < bound; i++) begin
                        if (!found && m_slot[k][i] == hash) begin
                            found = 1;
                            hit   = i;
                        end
                    end
                    p_mf[k] = found;
                    p_mi[k] = found ? hit : 0;
                    if (found)           m_left[k] = hit / lanes_c[k] + 1;
                    else if (bound == 0) m_left[k] = 1;
                    else                 m_left[k] = (bound + lanes_c[k] - 1) / lanes_c[k];
                    m_busy[k] = 1; m_rr[k] = 0; m_mf[k] = 0; m_mi[k] = 0;
                end
                if (ne) begin
                    if (m_cnt[k] < depth_c[k]) begin
                        m_slot[k][m_cnt[k]] = hash;
                        m_cnt[k]++;
                    end else begin
                        m_ovf[k] = 1;
                    end
                end
            end
        end
        prev_new = rst ? 1'b0 : newrdy;
        prev_chk = rst ? 1'b0 : checkrdy;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("count[%0d]", k),      64'(o_cnt[k]),  64'(m_cnt[k]));
            check_val($sformatf("full[%0d]", k),       64'(o_full[k]), 64'(m_cnt[k] == depth_c[k]));
            check_val($sformatf("overflow[%0d]", k),   64'(o_ovf[k]),  64'(m_ovf[k]));
            check_val($sformatf("busy[%0d]", k),       64'(o_busy[k]), 64'(m_busy[k]));
            check_val($sformatf("resultrdy[%0d]", k),  64'(o_rr[k]),   64'(m_rr[k]));
            check_val($sformatf("matchfound[%0d]", k), 64'(o_mf[k]),   64'(m_mf[k]));
            check_val($sformatf("matchidx[%0d]", k),   64'(o_mi[k]),   64'(m_mi[k]));
        end
    endtask

    task automatic step(input bit r, input bit c, input bit n, input bit q, input logic [127:0] h);
        rst = r; clear = c; newrdy = n; checkrdy = q; hash = h;
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, hash);
    endtask

    task automatic store(input logic [127:0] h);
        step(0, 0, 1, 0, h);
        step(0, 0, 1, 0, h);
        step(0, 0, 0, 0, h);
    endtask

    // Pulse a query, then count idle cycles until instance k shows a result.
    task automatic query(input logic [127:0] h, input int k, output int lat);
        step(0, 0, 0, 1, h);
        lat = 0;
        do begin
            step(0, 0, 0, 0, h);
            lat++;
        end while (!o_rr[k] && lat < 40);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] H_A = 128'h0CB6948805F797BF2A82807973B89537;
    localparam logic [127:0] H_B = 128'h7454070F0339BBC993CB08EAF741513A;
    localparam logic [127:0] H_C = 128'h61FB34469B9989B01BE4E8630C52EED6;
    localparam logic [127:0] H_D = 128'h7CE21F17C0AEE7FB9CEBA532D0546AD6;

    logic [127:0] vals [10];
    logic [127:0] pool [8];
    logic [127:0] x;
    int           lat;

    initial begin
        prev_new = 0; prev_chk = 0;
        foreach (m_cnt[k]) begin
            m_cnt[k] = 0; m_ovf[k] = 0; m_busy[k] = 0; m_rr[k] = 0;
            m_mf[k] = 0; m_mi[k] = 0; m_left[k] = 0; p_mf[k] = 0; p_mi[k] = 0;
        end
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        step(0, 0, 0, 0, '0);

        store(H_A); store(H_B); store(H_C);
        check_val("plan_count3", 64'(o_cnt[0]), 64'd3);
        check_val("plan_full0",  64'(o_full[0]), 64'd0);

        query(H_C, 0, lat);
        check_val("plan_hit_lat", 64'(lat), 64'd3);
        check_val("plan_hit_mf",  64'(o_mf[0]), 64'd1);
        check_val("plan_hit_idx", 64'(o_mi[0]), 64'd2);
        query(H_D, 0, lat);
        check_val("plan_miss_lat", 64'(lat), 64'd3);
        check_val("plan_miss_mf",  64'(o_mf[0]), 64'd0);

        store(rnd128());
        check_val("plan_d4_full", 64'(o_full[1]), 64'd1);
        store(rnd128());
        check_val("plan_d4_ovf", 64'(o_ovf[1]), 64'd1);
        check_val("plan_d4_cnt", 64'(o_cnt[1]), 64'd4);
        step(0, 1, 0, 0, hash);
        check_val("plan_clr_cnt", 64'(o_cnt[1]), 64'd0);
        query(H_A, 1, lat);
        check_val("plan_empty_lat", 64'(lat), 64'd1);

        foreach (vals[i]) begin
            vals[i] = rnd128();
            store(vals[i]);
        end
        query(vals[9], 2, lat);
        check_val("plan_l4_lat", 64'(lat), 64'd3);
        check_val("plan_l4_idx", 64'(o_mi[2]), 64'd9);
        store(vals[9]);
        query(vals[9], 2, lat);
        check_val("plan_dup_idx", 64'(o_mi[2]), 64'd9);

        x = rnd128();
        step(0, 0, 1, 1, x);
        step(0, 0, 0, 0, x);
        idle(6);
        check_val("plan_simul_mf", 64'(o_mf[2]), 64'd0);
        query(x, 2, lat);
        check_val("plan_requery_mf", 64'(o_mf[2]), 64'd1);

        step(0, 0, 0, 1, H_D);
        idle(3);
        step(0, 0, 0, 1, H_C);
        idle(20);
        step(0, 0, 0, 1, H_D);
        idle(2);
        step(1, 0, 0, 0, H_D);
        check_val("plan_rst_rr", 64'(o_rr[0]), 64'd0);
        idle(2);

        foreach (pool[i]) pool[i] = rnd128();
        for (int c = 0; c < 2000; c++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 4) == 0) ? rnd128() : pool[$urandom_range(0, 7)]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
